// File: rtl/cassette_rec_pkg.sv
// cassette_rec_pkg: constants and state encodings shared by the cassette
// recorder and its sampler (ADDR_W is also what the tape player uses).
package cassette_rec_pkg;

    localparam int unsigned CR_ADDR_W     = 25;
    localparam logic [15:0] CR_SAMPLE_DIV = 16'd185;  // must match square_gen bit period

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_SAMPLE  = 3'd2,
        ST_WRITE   = 3'd3,
        ST_WAITACK = 3'd4,
        ST_FULL    = 3'd5
    } cr_state_e;

    // Reported on status while the most recent byte was dropped.
    localparam logic [2:0] CR_STATUS_OVERRUN = 3'd7;

endpackage

// File: rtl/cassette_rec_tape_sampler.sv
// tape_sampler: bit-rate divider, mid-bit sampling of din and MSB-first
// byte assembly.
//   clk, reset  : system clock, async active-high reset
//   clr, start  : clear divider/shift/bit count (start also re-phases the divider)
//   run         : advance the divider and sample
//   din         : cassette-out level
//   byte_valid  : one-cycle pulse when byte_out holds a fresh complete byte
//   byte_out    : last complete byte (stable until the next one completes)
//   shift       : byte in progress, unfilled low bits are zero
//   bitcnt      : samples taken into shift (0..7)
module tape_sampler
    import cassette_rec_pkg::*;
#(
    parameter logic [15:0] SAMPLE_DIV = CR_SAMPLE_DIV
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       start,
    input  logic       run,
    input  logic       din,
    output logic       byte_valid,
    output logic [7:0] byte_out,
    output logic [7:0] shift,
    output logic [3:0] bitcnt
);

    localparam logic [15:0] MID = SAMPLE_DIV >> 1;

    logic [15:0] div_q, div_d;
    logic [3:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  byte_q, byte_d;
    logic        valid_q, valid_d;

    always_comb begin
        div_d    = div_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        byte_d   = byte_q;
        valid_d  = 1'b0;
        if (clr || start) begin
            div_d    = '0;
            bitcnt_d = '0;
            shift_d  = '0;
        end else if (run) begin
            div_d = (div_q == SAMPLE_DIV - 16'd1) ? 16'd0 : div_q + 16'd1;
            if (div_q == MID) begin
                // Bits land from bit 7 downward so a partial byte is already
                // zero-padded in its low bits.
                shift_d[3'd7 - bitcnt_q[2:0]] = din;
                if (bitcnt_q == 4'd7) begin
                    byte_d   = shift_d;
                    shift_d  = '0;
                    bitcnt_d = '0;
                    valid_d  = 1'b1;
                end else begin
                    bitcnt_d = bitcnt_q + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q    <= '0;
            bitcnt_q <= '0;
            shift_q  <= '0;
            byte_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            div_q    <= div_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            byte_q   <= byte_d;
            valid_q  <= valid_d;
        end
    end

    assign byte_valid = valid_q;
    assign byte_out   = byte_q;
    assign shift      = shift_q;
    assign bitcnt     = bitcnt_q;

endmodule

// File: rtl/cassette_rec.sv
// cassette_rec: records the ULA cassette-out line into the SDRAM tape buffer
// at the square_gen bit rate so the player replays it bit-exactly.
//   clk, reset       : system clock, async active-high reset
//   en               : record enable; recording starts on a rising edge only
//   rewind           : any toggle restarts at address 0 (beats everything)
//   din              : cassette-out level
//   tape_max         : last writable byte address
//   sdram_addr/data  : write address / data
//   sdram_wr         : write request, held until sdram_ack
//   sdram_ack        : one-cycle write-complete pulse
//   tape_end         : address of the last byte written
//   status           : state encoding, 7 while a byte has just been dropped
module cassette_rec
    import cassette_rec_pkg::*;
#(
    parameter logic [15:0] SAMPLE_DIV = CR_SAMPLE_DIV,
    parameter int unsigned ADDR_W     = CR_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              rewind,
    input  logic              din,
    input  logic [ADDR_W-1:0] tape_max,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [7:0]        sdram_data,
    output logic              sdram_wr,
    input  logic              sdram_ack,
    output logic [ADDR_W-1:0] tape_end,
    output logic [2:0]        status
);

    cr_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, tape_end_q, tape_end_d;
    logic [7:0]        data_q, data_d;
    logic              wr_q, wr_d;
    logic              stop_q, stop_d;    // en has fallen: finish writes, then IDLE
    logic              flush_q, flush_d;  // next WRITE sends the partial byte
    logic              ovr_q, ovr_d;
    logic              en_q, rew_q, din_q;

    logic       smp_clr, smp_start, smp_run, smp_valid;
    logic [7:0] smp_byte, smp_shift;
    logic [3:0] smp_bitcnt;

    wire en_rise  = en & ~en_q;
    wire en_fall  = ~en & en_q;
    wire rew_edge = rewind ^ rew_q;
    wire din_edge = din ^ din_q;

    // Sampling keeps running while a write is outstanding; the sampler's
    // shift register is the second half of the double buffer.
    assign smp_run = !stop_q && (state_q == ST_SAMPLE || state_q == ST_WRITE ||
                                 state_q == ST_WAITACK);

    tape_sampler #(.SAMPLE_DIV(SAMPLE_DIV)) u_sampler (
        .clk        (clk),
        .reset      (reset),
        .clr        (smp_clr),
        .start      (smp_start),
        .run        (smp_run),
        .din        (din),
        .byte_valid (smp_valid),
        .byte_out   (smp_byte),
        .shift      (smp_shift),
        .bitcnt     (smp_bitcnt)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        tape_end_d = tape_end_q;
        data_d     = data_q;
        wr_d       = wr_q;
        stop_d     = stop_q;
        flush_d    = flush_q;
        ovr_d      = ovr_q;
        smp_clr    = 1'b0;
        smp_start  = 1'b0;
        if (rew_edge) begin
            state_d    = ST_IDLE;
            addr_d     = '0;
            tape_end_d = '0;
            wr_d       = 1'b0;
            stop_d     = 1'b0;
            flush_d    = 1'b0;
            ovr_d      = 1'b0;
            smp_clr    = 1'b1;
        end else begin
            if (en_fall) stop_d = 1'b1;
            // A byte completing while the previous write is still unacked is lost.
            if (smp_valid) ovr_d = (state_q == ST_WAITACK) && !sdram_ack;
            case (state_q)
                ST_IDLE: if (en_rise) state_d = ST_ARM;
                ST_ARM: begin
                    if (en_fall) begin
                        state_d = ST_IDLE;
                    end else if (din_edge) begin
                        smp_start = 1'b1;
                        state_d   = ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    if (smp_valid) begin
                        state_d = ST_WRITE;
                    end else if (en_fall) begin
                        flush_d = (smp_bitcnt != 4'd0);
                        state_d = (smp_bitcnt != 4'd0) ? ST_WRITE : ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    data_d  = flush_q ? smp_shift : smp_byte;
                    smp_clr = flush_q;
                    flush_d = 1'b0;
                    wr_d    = 1'b1;
                    state_d = ST_WAITACK;
                end
                ST_WAITACK: begin
                    if (sdram_ack) begin
                        wr_d       = 1'b0;
                        tape_end_d = addr_q;
                        if (addr_q == tape_max) begin
                            state_d = stop_d ? ST_IDLE : ST_FULL;
                        end else begin
                            addr_d = addr_q + ADDR_W'(1);
                            if (smp_valid) begin
                                state_d = ST_WRITE;
                            end else if (stop_d) begin
                                flush_d = (smp_bitcnt != 4'd0);
                                state_d = (smp_bitcnt != 4'd0) ? ST_WRITE : ST_IDLE;
                            end else begin
                                state_d = ST_SAMPLE;
                            end
                        end
                    end
                end
                ST_FULL: if (en_fall) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
            if (state_d == ST_IDLE) begin
                stop_d  = 1'b0;
                flush_d = 1'b0;
                ovr_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            tape_end_q <= '0;
            data_q     <= '0;
            wr_q       <= 1'b0;
            stop_q     <= 1'b0;
            flush_q    <= 1'b0;
            ovr_q      <= 1'b0;
            en_q       <= 1'b0;
            rew_q      <= 1'b0;
            din_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            tape_end_q <= tape_end_d;
            data_q     <= data_d;
            wr_q       <= wr_d;
            stop_q     <= stop_d;
            flush_q    <= flush_d;
            ovr_q      <= ovr_d;
            en_q       <= en;
            rew_q      <= rewind;
            din_q      <= din;
        end
    end

    assign sdram_addr = addr_q;
    assign sdram_data = data_q;
    assign sdram_wr   = wr_q;
    assign tape_end   = tape_end_q;
    assign status     = ovr_q ? CR_STATUS_OVERRUN : state_q;

endmodule

// File: tb/tb_cassette_rec.sv
// tb_cassette_rec: streams random and directed bit patterns through the
// recorder and compares every SDRAM write request, tape_end and address
// against a byte-level model of the recording rules.
module tb_cassette_rec;
    import cassette_rec_pkg::*;

    localparam int SD = 185;
    localparam int AW = 25;

    typedef bit         bitq_t[$];
    typedef logic [7:0] byteq_t[$];
    typedef struct packed { logic [AW-1:0] a; logic [7:0] d; } wr_t;

    logic          clk = 1'b0;
    logic          reset, en, rewind, din, sdram_ack;
    logic [AW-1:0] tape_max, sdram_addr, tape_end;
    logic [7:0]    sdram_data;
    logic          sdram_wr;
    logic [2:0]    status;

    int            n_cmp = 0, n_bad = 0;
    int            ack_dly = 3;
    bit            ack_hold = 1'b0;
    wr_t           obs_q[$], exp_q[$];
    logic [AW-1:0] m_addr, m_tape_end;
    bit            m_full;

    always #5 clk = ~clk;

    cassette_rec #(.SAMPLE_DIV(16'd185), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .en(en), .rewind(rewind), .din(din),
        .tape_max(tape_max), .sdram_addr(sdram_addr), .sdram_data(sdram_data),
        .sdram_wr(sdram_wr), .sdram_ack(sdram_ack), .tape_end(tape_end),
        .status(status)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // SDRAM side: ack each request after ack_dly cycles.
    initial begin
        sdram_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (sdram_wr && !ack_hold) begin
                repeat (ack_dly - 1) @(negedge clk);
                sdram_ack = 1'b1;
                @(negedge clk);
                sdram_ack = 1'b0;
            end
        end
    end

    // Record each new write request.
    initial begin
        bit seen;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (sdram_wr && !seen) obs_q.push_back('{sdram_addr, sdram_data});
            seen = sdram_wr;
        end
    end

    // Bits -> bytes, MSB first, trailing partial byte zero-padded.
    task automatic pack(input bitq_t b, output byteq_t q);
        q = {};
        for (int k = 0; k * 8 < b.size(); k++) begin
            logic [7:0] v;
            v = 8'h00;
            for (int j = 0; j < 8; j++)
                if (k * 8 + j < b.size() && b[k * 8 + j]) v[7 - j] = 1'b1;
            q.push_back(v);
        end
    endtask

    // Bytes go to consecutive addresses until the one at tape_max is written.
    task automatic commit(input byteq_t by);
        m_full = 1'b0;
        foreach (by[i]) begin
            if (!m_full) begin
                exp_q.push_back('{m_addr, by[i]});
                m_tape_end = m_addr;
                if (m_addr == tape_max) m_full = 1'b1;
                else m_addr = m_addr + 1;
            end
        end
    endtask

    task automatic rand_bits(input int n, output bitq_t b);
        b = {};
        for (int i = 0; i < n; i++) b.push_back(bit'($urandom_range(0, 1)));
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        @(negedge clk);
        while (status != ST_IDLE && c < 4000) begin
            @(negedge clk);
            c++;
        end
        chk("idle_timeout", 32'(status), 32'(ST_IDLE));
    endtask

    task automatic play(input bitq_t b, input int probe_bit, input logic [2:0] probe_st,
                        input int rew_bit);
        din = ~b[0];
        repeat (3) @(negedge clk);
        en = 1'b1;
        repeat (5) @(negedge clk);
        for (int i = 0; i < b.size(); i++) begin
            din = b[i];
            repeat (SD) @(negedge clk);
            if (i == probe_bit) chk("probe_status", 32'(status), 32'(probe_st));
            if (i == rew_bit) rewind = ~rewind;
        end
        en = 1'b0;
        wait_idle();
    endtask

    task automatic check_writes();
        chk("n_writes", 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            chk("wr_addr", 32'(obs_q[i].a), 32'(exp_q[i].a));
            chk("wr_data", 32'(obs_q[i].d), 32'(exp_q[i].d));
        end
        obs_q.delete();
        exp_q.delete();
        chk("tape_end", 32'(tape_end), 32'(m_tape_end));
        chk("addr", 32'(sdram_addr), 32'(m_addr));
    endtask

    initial begin
        bitq_t  bits;
        byteq_t by;
        reset = 1'b1; en = 1'b0; rewind = 1'b0; din = 1'b0;
        tape_max = 25'd1000;
        m_addr = '0; m_tape_end = '0; m_full = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_status", 32'(status), 32'(ST_IDLE));
        chk("rst_addr", 32'(sdram_addr), 32'd0);
        chk("rst_wr", 32'(sdram_wr), 32'd0);
        chk("rst_data", 32'(sdram_data), 32'd0);
        chk("rst_tape_end", 32'(tape_end), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // 1,0,1,0,0,0,0,1 -> A1 at address 0
        bits = '{1, 0, 1, 0, 0, 0, 0, 1};
        pack(bits, by);
        chk("pack_a1", 32'(by[0]), 32'h0000_00A1);
        commit(by);
        play(bits, -1, 3'd0, -1);
        check_writes();

        // random byte streams with random partial tails and ack latencies
        repeat (4) begin
            ack_dly = $urandom_range(1, 40);
            rand_bits(8 * $urandom_range(1, 3) + $urandom_range(0, 7), bits);
            pack(bits, by);
            commit(by);
            play(bits, -1, 3'd0, -1);
            check_writes();
        end
        ack_dly = 3;

        // partial 1,1,1 -> E0
        bits = '{1, 1, 1};
        pack(bits, by);
        commit(by);
        play(bits, -1, 3'd0, -1);
        check_writes();

        // ack held past a byte time: second byte dropped, third follows directly
        ack_dly = 9 * SD;
        rand_bits(24, bits);
        pack(bits, by);
        by.delete(1);
        commit(by);
        play(bits, 15, CR_STATUS_OVERRUN, -1);
        check_writes();
        ack_dly = 3;

        // rewind from idle, then fill a 3-byte tape with 4 bytes
        rewind = ~rewind;
        repeat (2) @(negedge clk);
        m_addr = '0; m_tape_end = '0;
        check_writes();
        tape_max = 25'd2;
        rand_bits(32, bits);
        pack(bits, by);
        commit(by);
        play(bits, 31, ST_FULL, -1);
        check_writes();
        tape_max = 25'd1000;

        // rewind mid-byte after 5 bytes; the rest of the stream with en held
        // high must not restart recording
        rand_bits(48, bits);
        pack(bits, by);
        while (by.size() > 5) void'(by.pop_back());
        commit(by);
        play(bits, 42, ST_SAMPLE, 43);
        m_addr = '0; m_tape_end = '0;
        check_writes();
        rand_bits(16, bits);
        pack(bits, by);
        commit(by);
        play(bits, -1, 3'd0, -1);
        check_writes();

        // reset while a write is outstanding
        ack_hold = 1'b1;
        rand_bits(8, bits);
        pack(bits, by);
        commit(by);
        din = ~bits[0];
        repeat (3) @(negedge clk);
        en = 1'b1;
        repeat (5) @(negedge clk);
        foreach (bits[i]) begin
            din = bits[i];
            repeat (SD) @(negedge clk);
        end
        begin
            int c;
            c = 0;
            while (!sdram_wr && c < 400) begin
                @(negedge clk);
                c++;
            end
        end
        chk("wa_status", 32'(status), 32'(ST_WAITACK));
        reset = 1'b1;
        en = 1'b0;
        #1;
        chk("rst_mid_wr", 32'(sdram_wr), 32'd0);
        chk("rst_mid_addr", 32'(sdram_addr), 32'd0);
        chk("rst_mid_status", 32'(status), 32'(ST_IDLE));
        @(negedge clk);
        reset = 1'b0;
        ack_hold = 1'b0;
        @(negedge clk);
        chk("post_rst_status", 32'(status), 32'(ST_IDLE));
        m_addr = '0; m_tape_end = '0;
        check_writes();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
